// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin, packet-locked arbiter sharing one UART TX
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [7:0]           uart_data_o,
  output logic                 uart_send_o,
  input  logic                 uart_tx_done_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ready;

  logic [7:0]         req_byte [N_REQ];
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic [N_REQ-1:0]   win_oh;
  logic [PTR_W-1:0]   next_ptr;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_byte[k] = req_data_i[8*k +: 8];
  end

  // Round-robin search starting at ptr_q, wrapping at N_REQ (need not be a power of two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
      if (!win_found && req_valid_i[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign win_oh   = N_REQ'(1) << win_idx;
  assign next_ptr = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    grant_d = grant_q;
    ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          ready   = win_oh;
          data_d  = req_byte[win_idx];
          last_d  = req_last_i[win_idx];
          grant_d = win_oh;
          owner_d = win_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (uart_tx_done_i) begin
          if (last_q) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = next_ptr;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        // Only the lock owner may continue; an acceptance beats a coincident timeout.
        ready = grant_q & req_valid_i;
        if (req_valid_i[owner_q]) begin
          data_d  = req_byte[owner_q];
          last_d  = req_last_i[owner_q];
          cnt_d   = '0;
          state_d = ST_SEND;
        end else if (cnt_q == CNT_W'(HOLD_TIMEOUT - 1)) begin
          cnt_d   = '0;
          grant_d = '0;
          ptr_d   = next_ptr;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_ni) ready = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign req_ready_o = ready;
  assign uart_data_o = data_q;
  assign uart_send_o = (state_q == ST_SEND);
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
